lli_wb_scheduler: RTL
=====================

# lli_wb_scheduler

Scoreboard and writeback scheduler for the long-latency execution units (integer divider, FP divider, FP sqrt). It sits beside the decode/execute pipeline. It tracks which architectural registers have a result still pending in a multi-cycle unit, and raises the RAW/WAW busy indications consumed by the stall logic and the forwarded-value capture stage. It also arbitrates the single shared register-file write port between finished units and the in-order pipeline, and signals a `collision` when the pipeline must yield that port.

## Interface
- `NUM_UNITS`, 3: number of long-latency units (2..8).
- `n`, 32: result data width.
- `FP_type`, 0: 0 = integer register file (x0 never busy), 1 = FP register file (f0 trackable).
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: instruction in EXE dispatched to a long-latency unit this cycle.
- `issue_rd` in 5: its destination register.
- `rs1_id`, `rs2_id`, `rs3_id` in 5 each: source registers of the instruction in ID.
- `rd_id` in 5: destination of the instruction in ID.
- `rd_used_id` in 1: ID instruction writes a register.
- `busy_rs1`, `busy_rs2`, `busy_rs3` out 1 each: that source has a pending long-latency result (RAW).
- `rd_not_busy` out 1: `rd_id` has no pending result (WAW clear); 1 when `rd_used_id`=0.
- `unit_done` in NUM_UNITS: unit k holds a finished result.
- `unit_rd` in NUM_UNITS*5: destination of unit k, packed as k*5 +: 5.
- `unit_result` in NUM_UNITS*n: result of unit k, packed as k*n +: n.
- `unit_ack` out NUM_UNITS: one-hot; unit k's result is written this cycle.
- `pipe_wb_valid` in 1: the in-order WB stage wants the write port.
- `wb_en` out 1, `wb_rd` out 5, `wb_data` out n: long-latency write-port request.
- `collision` out 1: a unit owns the port while `pipe_wb_valid`=1; the pipeline holds for one cycle.
- `pending_cnt` out 4: number of registers currently busy, saturating at 15.
- `lli_idle` out 1: `pending_cnt`==0 and no `unit_done`.

## Operation
- State:
  - `busy[31:0]` scoreboard.
  - `rr_ptr` round-robin pointer, $clog2(NUM_UNITS) bits.
  - `pending_cnt` counter.
- Issue: when `issue_valid` is set, `busy[issue_rd]` is set on the next edge.
  - `issue_rd`==0 with FP_type=0 is ignored.
- Arbitration:
  - Among the set `unit_done` bits, grant the first one at or after `rr_ptr`, searching cyclically.
  - Grant drives `unit_ack[g]`=1, `wb_en`=1, `wb_rd`=`unit_rd[g]` and `wb_data`=`unit_result[g]` combinationally.
  - On the next edge, `rr_ptr` becomes (g+1) mod NUM_UNITS and `busy[wb_rd]` is cleared.
  - With no request, `rr_ptr` holds and `wb_en`=0, `wb_rd`=0, `wb_data`=0.
- Collision:
  - `collision` = `wb_en` & `pipe_wb_valid`. The unit always wins the port.
  - Any unit is granted within NUM_UNITS cycles of raising `unit_done`. Pipeline hold is bounded by the number of consecutive unit grants.
- Busy outputs: `busy_rsX` = `busy[rsX_id]`. `rd_not_busy` = ~`busy[rd_id]` | ~`rd_used_id`. With FP_type=0, index 0 always reads 0.
- Same-register set and clear in one cycle (issue to R while R is being written back): the set wins and `busy[R]`=1 afterwards.
- `pending_cnt` is the population count of `busy`, registered. It increments on set-only, decrements on clear-only, and holds when both or neither happen.
- `unit_done` for a register whose busy bit is 0 still gets granted and written, and the counter does not underflow. Verification flags this as an assertion error.

## Timing
- Reset: `busy`=0, `rr_ptr`=0, `pending_cnt`=0. With `unit_done`=0, all outputs are 0 except `rd_not_busy`=1 and `lli_idle`=1.
- Reset asserted mid-operation clears all state immediately. Outstanding unit results are discarded by the units' own reset.
- Issue at edge t: busy visible to ID from cycle t+1.
- `unit_done` high in cycle t: `unit_ack`/`wb_en` in the same cycle t if granted. The busy bit drops at t+1.
- A unit holds `unit_done`, `unit_rd` and `unit_result` stable until it sees `unit_ack`.

## Configuration
- `LLI_WB_BYPASS_EN`, defined:
  - A register being written back this cycle reads as not busy: `busy_rsX` and `rd_not_busy` are masked by `wb_en && wb_rd==rsX_id`.
  - The stall ends one cycle earlier. The consumer takes the value through the WB forward path.
- Not defined: busy outputs come from the registered bits only, giving one extra stall cycle after the writeback.

## Test plan
- Issue rd=5, then `unit_done[1]`=1, `unit_rd`=5 three cycles later, with `rs1_id`=5 → `busy_rs1`=1 from t+1 until the ack cycle. `wb_rd`=5, `unit_ack`=3'b010. Bypass off: `busy_rs1`=0 one cycle after ack. Bypass on: 0 in the ack cycle.
- All three `unit_done` high together from reset → acks 001, 010, 100 on consecutive cycles. `rr_ptr` ends at 0.
- `unit_done[2]` with `pipe_wb_valid`=1 → `collision`=1 and `wb_rd`=`unit_rd[2]` for exactly that cycle.
- Issue rd=0 with FP_type=0 → `pending_cnt` stays 0 and `busy_rs1`(rs1=0)=0. With FP_type=1 → `pending_cnt`=1.
- Issue rd=9 in the same cycle as writeback of rd=9 → `busy[9]`=1 after the edge, `pending_cnt` unchanged.
- Issue 4 registers, then assert reset_n=0 mid-run → `pending_cnt`=0, `lli_idle`=1 and `rd_not_busy`=1, without waiting for a clock edge.

Source files
------------

// File: rtl/lli_wb_scheduler.sv
// Scoreboard and shared write-port scheduler for the long-latency units (int div, fp div, fp sqrt).
// Optional macro LLI_WB_BYPASS_EN: a register being written back this cycle already reads as not busy.
module lli_wb_scheduler #(
    parameter int NUM_UNITS = 3,
    parameter int n         = 32,
    parameter int FP_type   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic [4:0]             rs3_id,
    input  logic [4:0]             rd_id,
    input  logic                   rd_used_id,
    output logic                   busy_rs1,
    output logic                   busy_rs2,
    output logic                   busy_rs3,
    output logic                   rd_not_busy,
    input  logic [NUM_UNITS-1:0]   unit_done,
    input  logic [NUM_UNITS*5-1:0] unit_rd,
    input  logic [NUM_UNITS*n-1:0] unit_result,
    output logic [NUM_UNITS-1:0]   unit_ack,
    input  logic                   pipe_wb_valid,
    output logic                   wb_en,
    output logic [4:0]             wb_rd,
    output logic [n-1:0]           wb_data,
    output logic                   collision,
    output logic [3:0]             pending_cnt,
    output logic                   lli_idle
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [31:0]      busy;
    logic [31:0]      busy_nxt;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic [31:0]      busy_view;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_nxt;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic [5:0]       pop;
    logic [3:0]       cnt_nxt;
    logic             issue_set;

    logic [4:0]   rd_arr  [NUM_UNITS];
    logic [n-1:0] res_arr [NUM_UNITS];

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
        assign rd_arr[k]  = unit_rd[k*5 +: 5];
        assign res_arr[k] = unit_result[k*n +: n];
    end

    // Cyclic search starting at rr_ptr; first requester found wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_UNITS);
            if (!grant_found && unit_done[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        unit_ack = '0;
        if (grant_found) begin
            unit_ack[grant_idx] = 1'b1;
        end
    end

    assign wb_en     = grant_found;
    assign wb_rd     = grant_found ? rd_arr[grant_idx] : 5'd0;
    assign wb_data   = grant_found ? res_arr[grant_idx] : '0;
    assign collision = wb_en & pipe_wb_valid;

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (grant_found) begin
            rr_ptr_nxt = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign issue_set = issue_valid && !((FP_type == 0) && (issue_rd == 5'd0));
    assign set_mask  = issue_set ? (32'd1 << issue_rd) : 32'd0;
    assign clr_mask  = wb_en ? (32'd1 << wb_rd) : 32'd0;
    // Set is applied after clear so a same-register issue wins over its own writeback.
    assign busy_nxt  = (busy & ~clr_mask) | set_mask;

    // Counter tracks the population of the next scoreboard, so a clear of an idle bit cannot underflow.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) begin
            pop = pop + 6'(busy_nxt[i]);
        end
        cnt_nxt = (pop > 6'd15) ? 4'd15 : pop[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            rr_ptr      <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            rr_ptr      <= rr_ptr_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        busy_view = busy;
        if (FP_type == 0) begin
            busy_view[0] = 1'b0;
        end
`ifdef LLI_WB_BYPASS_EN
        if (wb_en) begin
            busy_view[wb_rd] = 1'b0;
        end
`else
`endif
    end

    assign busy_rs1    = busy_view[rs1_id];
    assign busy_rs2    = busy_view[rs2_id];
    assign busy_rs3    = busy_view[rs3_id];
    assign rd_not_busy = ~busy_view[rd_id] | ~rd_used_id;
    assign lli_idle    = (pending_cnt == 4'd0) && !(|unit_done);

endmodule
